multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1; 1 = memory states wait on mem_ready, 0 = mem_ready ignored and treated as 1.
REQ-002 SHALL have parameter ENABLE_JAL, default 1; 0 = opcode 6'h3 treated as illegal.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port OP  input  6  instruction opcode, sampled in DECODE only.
REQ-006 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-007 SHALL have ports PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite  output  1 each  standard multicycle datapath enables.
REQ-008 SHALL have ports ALUSrcB, PCSource, RegDst, MemtoReg  output  2 each  datapath mux selects.
REQ-009 SHALL have port ALUOp  output  3  ALU control code.
REQ-010 SHALL have port illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-011 SHALL have port state  output  4  current state, for debug.

Function
REQ-012 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC, ALUWB, BRANCH, JUMP.
REQ-013 Outputs SHALL be Moore, decoded from state and latched op class; the only exception is mem_ready gating per REQ-016.
REQ-014 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=110, PCSource=00; it SHALL pulse IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1, then go to DECODE.
REQ-015 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=110, and latch OP into an op-class register. Next state:
  - R-type, ADDI/ANDI/ORI/LUI -> EXEC
  - LW/SW -> MEMADR
  - BEQ/BNE -> BRANCH
  - J/JAL -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 for that cycle
REQ-016 MEMREAD (MemRead=1, IorD=1) and MEMWRITE (MemWrite=1, IorD=1) SHALL hold state while mem_ready=0. MemWrite SHALL stay asserted across wait cycles. Exit occurs on the mem_ready=1 cycle.
REQ-017 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=010 (LW) or 100 (SW), then go to MEMREAD (LW) or MEMWRITE (SW).
REQ-018 MEMWB SHALL drive RegWrite=1, RegDst=00, MemtoReg=01, then go to FETCH.
REQ-019 EXEC SHALL drive ALUSrcA=1 and the following ALUSrcB/ALUOp pairs, then go to ALUWB:
  - R-type: ALUSrcB=00, ALUOp=111
  - ADDI: ALUSrcB=10, ALUOp=110
  - ANDI: ALUSrcB=10, ALUOp=011
  - ORI: ALUSrcB=10, ALUOp=101
  - LUI: ALUSrcB=10, ALUOp=001
REQ-020 ALUWB SHALL drive RegWrite=1, MemtoReg=00, RegDst=01 (R-type) or 00 (immediate), holding the EXEC ALUSrcB/ALUOp, then go to FETCH.
REQ-021 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=000, PCWriteCond=1, PCSource=01, and BranchNE=1 for BNE only, then go to FETCH.
REQ-022 JUMP SHALL drive PCWrite=1 and PCSource=10, then go to FETCH. For JAL it SHALL also drive RegWrite=1, RegDst=10 ($ra), MemtoReg=10 (PC).
REQ-023 Every signal not listed for a state SHALL be 0.
REQ-024 Cycle counts with mem_ready always 1 SHALL be:
  - LW 5
  - R-type, immediate, SW 4
  - BEQ/BNE, J, JAL 3
  - illegal 2
REQ-025 The state register SHALL never hold an unlisted encoding. Any such value SHALL return to FETCH on the next edge.

Reset
REQ-026 While reset=1, state SHALL load FETCH at the next clock edge and every output SHALL be 0, including MemRead, IRWrite and illegal_op.
REQ-027 Reset asserted mid-instruction, including during a memory wait, SHALL abort the instruction; no RegWrite/PCWrite/MemWrite pulse SHALL occur after the reset edge.
REQ-028 The first FETCH cycle SHALL be the first cycle with reset=0.

Structure
REQ-029 A shared package SHALL hold the opcode constants (R=0, ADDI=08, ANDI=0C, ORI=0D, LUI=0F, LW=23, SW=2B, BEQ=04, BNE=05, J=02, JAL=03), the ALUOp codes, the state enum, and the mux-select encodings.
REQ-030 Opcode classification SHALL live in one combinational sub-module, mips_opcode_decode: OP in, op class and legal flag out.

Verification
REQ-031 ADDI, mem_ready=1 -> FETCH, DECODE, EXEC (ALUOp=110, ALUSrcB=10), ALUWB (RegWrite=1, RegDst=00); 4 cycles.
REQ-032 LW with mem_ready low for 3 cycles in MEMREAD -> MemRead/IorD held 4 cycles, MEMWB (MemtoReg=01) follows; total 8 cycles.
REQ-033 BNE -> BRANCH with PCWriteCond=1, BranchNE=1, ALUOp=000; back in FETCH at cycle 4.
REQ-034 JAL, ENABLE_JAL=1 -> JUMP with PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10. With ENABLE_JAL=0 -> illegal_op pulse in DECODE and no RegWrite.
REQ-035 SW waiting in MEMWRITE, then reset=1 for one cycle -> MemWrite=0 from the reset cycle, state=FETCH next, no write pulse.
REQ-036 OP=6'h3F -> illegal_op=1 for exactly one cycle; next state FETCH; all enables 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, ALUOp codes,
// datapath mux selects, FSM states, and the latched opcode class.
package multicycle_control_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned CLASS_W = 4;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // ALUOp codes
    localparam logic [ALUOP_W-1:0] ALU_BRCMP = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_LUI   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_LWADR = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_SWADR = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b101;
    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b110;
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b111;

    // Mux selects
    localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_BRANCH = 2'b11;
    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] REGDST_RT = 2'b00;
    localparam logic [SEL_W-1:0] REGDST_RD = 2'b01;
    localparam logic [SEL_W-1:0] REGDST_RA = 2'b10;
    localparam logic [SEL_W-1:0] M2R_ALU = 2'b00;
    localparam logic [SEL_W-1:0] M2R_MEM = 2'b01;
    localparam logic [SEL_W-1:0] M2R_PC  = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9
    } state_t;

    typedef enum logic [CLASS_W-1:0] {
        OPC_RTYPE = 4'd0,
        OPC_ADDI  = 4'd1,
        OPC_ANDI  = 4'd2,
        OPC_ORI   = 4'd3,
        OPC_LUI   = 4'd4,
        OPC_LW    = 4'd5,
        OPC_SW    = 4'd6,
        OPC_BEQ   = 4'd7,
        OPC_BNE   = 4'd8,
        OPC_J     = 4'd9,
        OPC_JAL   = 4'd10,
        OPC_NONE  = 4'd11
    } op_class_t;

    // {ALUSrcB, ALUOp} used in EXEC and held through ALUWB
    function automatic logic [SEL_W+ALUOP_W-1:0] exec_sel(input op_class_t c);
        case (c)
            OPC_RTYPE: exec_sel = {SRCB_REG, ALU_FUNCT};
            OPC_ADDI:  exec_sel = {SRCB_IMM, ALU_ADD};
            OPC_ANDI:  exec_sel = {SRCB_IMM, ALU_AND};
            OPC_ORI:   exec_sel = {SRCB_IMM, ALU_OR};
            OPC_LUI:   exec_sel = {SRCB_IMM, ALU_LUI};
            default:   exec_sel = {SRCB_REG, ALU_BRCMP};
        endcase
    endfunction

endpackage

// File: rtl/mips_opcode_decode.sv
// Combinational opcode classifier.
//   i_op       : instruction opcode
//   o_op_class : class of the opcode (OPC_NONE when unsupported)
//   o_legal    : 1 when the opcode is supported
module mips_opcode_decode
    import multicycle_control_pkg::*;
#(
    parameter bit ENABLE_JAL = 1'b1
) (
    input  logic [OP_W-1:0] i_op,
    output op_class_t       o_op_class,
    output logic            o_legal
);

    always_comb begin
        o_op_class = OPC_NONE;
        o_legal    = 1'b1;
        case (i_op)
            OP_RTYPE: o_op_class = OPC_RTYPE;
            OP_ADDI:  o_op_class = OPC_ADDI;
            OP_ANDI:  o_op_class = OPC_ANDI;
            OP_ORI:   o_op_class = OPC_ORI;
            OP_LUI:   o_op_class = OPC_LUI;
            OP_LW:    o_op_class = OPC_LW;
            OP_SW:    o_op_class = OPC_SW;
            OP_BEQ:   o_op_class = OPC_BEQ;
            OP_BNE:   o_op_class = OPC_BNE;
            OP_J:     o_op_class = OPC_J;
            OP_JAL: begin
                if (ENABLE_JAL) o_op_class = OPC_JAL;
                else            o_legal    = 1'b0;
            end
            default:  o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath with optional memory handshake.
//   clk, reset        : clock, synchronous active-high reset
//   OP                : opcode, sampled in DECODE
//   mem_ready         : memory completes the current access this cycle
//   PCWrite..RegWrite : datapath enables
//   ALUSrcB, PCSource, RegDst, MemtoReg : mux selects
//   ALUOp             : ALU control code
//   illegal_op        : pulse in DECODE for an unsupported opcode
//   state             : current state (debug)
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ENABLE_JAL    = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    OP,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNE,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic [SEL_W-1:0]   ALUSrcB,
    output logic [SEL_W-1:0]   PCSource,
    output logic [SEL_W-1:0]   RegDst,
    output logic [SEL_W-1:0]   MemtoReg,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t    r_state;
    state_t    w_next_state;
    op_class_t r_op_class;
    op_class_t w_dec_class;
    logic      w_dec_legal;
    logic      w_mem_ready;

    assign w_mem_ready = mem_ready | ~MEM_HANDSHAKE;

    mips_opcode_decode #(
        .ENABLE_JAL (ENABLE_JAL)
    ) u_decode (
        .i_op       (OP),
        .o_op_class (w_dec_class),
        .o_legal    (w_dec_legal)
    );

    // State register and op-class latch (captured on the DECODE edge)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_op_class <= OPC_NONE;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) r_op_class <= w_dec_class;
        end
    end

    // Next state and Moore outputs; reset forces every output to zero
    always_comb begin
        w_next_state = S_FETCH;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        BranchNE     = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        ALUSrcA      = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcB      = SRCB_REG;
        PCSource     = PCSRC_ALU;
        RegDst       = REGDST_RT;
        MemtoReg     = M2R_ALU;
        ALUOp        = ALU_BRCMP;
        illegal_op   = 1'b0;
        state        = reset ? STATE_W'(0) : STATE_W'(r_state);

        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    MemRead  = 1'b1;
                    ALUSrcB  = SRCB_FOUR;
                    ALUOp    = ALU_ADD;
                    PCSource = PCSRC_ALU;
                    if (w_mem_ready) begin
                        IRWrite      = 1'b1;
                        PCWrite      = 1'b1;
                        w_next_state = S_DECODE;
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end
                S_DECODE: begin
                    ALUSrcB    = SRCB_BRANCH;
                    ALUOp      = ALU_ADD;
                    illegal_op = ~w_dec_legal;
                    case (w_dec_class)
                        OPC_RTYPE, OPC_ADDI, OPC_ANDI,
                        OPC_ORI, OPC_LUI:        w_next_state = S_EXEC;
                        OPC_LW, OPC_SW:          w_next_state = S_MEMADR;
                        OPC_BEQ, OPC_BNE:        w_next_state = S_BRANCH;
                        OPC_J, OPC_JAL:          w_next_state = S_JUMP;
                        default:                 w_next_state = S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    if (r_op_class == OPC_SW) begin
                        ALUOp        = ALU_SWADR;
                        w_next_state = S_MEMWRITE;
                    end else begin
                        ALUOp        = ALU_LWADR;
                        w_next_state = S_MEMREAD;
                    end
                end
                S_MEMREAD: begin
                    MemRead      = 1'b1;
                    IorD         = 1'b1;
                    w_next_state = w_mem_ready ? S_MEMWB : S_MEMREAD;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    RegDst   = REGDST_RT;
                    MemtoReg = M2R_MEM;
                end
                S_MEMWRITE: begin
                    MemWrite     = 1'b1;
                    IorD         = 1'b1;
                    w_next_state = w_mem_ready ? S_FETCH : S_MEMWRITE;
                end
                S_EXEC: begin
                    ALUSrcA            = 1'b1;
                    {ALUSrcB, ALUOp}   = exec_sel(r_op_class);
                    w_next_state       = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite           = 1'b1;
                    MemtoReg           = M2R_ALU;
                    RegDst             = (r_op_class == OPC_RTYPE) ? REGDST_RD : REGDST_RT;
                    {ALUSrcB, ALUOp}   = exec_sel(r_op_class);
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = SRCB_REG;
                    ALUOp       = ALU_BRCMP;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                    BranchNE    = (r_op_class == OPC_BNE);
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                    if (r_op_class == OPC_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = REGDST_RA;
                        MemtoReg = M2R_PC;
                    end
                end
                default: w_next_state = S_FETCH;
            endcase
        end
    end

endmodule
